// File: rtl/srl16_shift_reg_pkg.sv
// Shared sizing and helpers for the 16-tap serial shift register.
package srl16_shift_reg_pkg;

  localparam int unsigned TAP_COUNT = 16;
  localparam int unsigned ADDR_W    = 4;

  typedef logic [ADDR_W-1:0]    tap_addr_t;
  typedef logic [TAP_COUNT-1:0] taps_t;

  // New bit enters at tap 0; the old last tap falls off the end.
  function automatic taps_t shift_taps(input taps_t cur, input logic din);
    return {cur[TAP_COUNT-2:0], din};
  endfunction

endpackage

// File: rtl/srl16_shift_reg.sv
// SRL16E-style 16x1 shift register with asynchronous tap read and synchronous reload to INIT.
// Latency: bit shifted at edge n is on tap A after edge n+A; no backpressure (ce only gates shifting).
module srl16_shift_reg
  import srl16_shift_reg_pkg::*;
#(
  parameter logic [15:0] INIT = 16'h0000
) (
  input  logic clock,
  input  logic reset,
  input  logic ce,
  input  logic d,
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  output logic q,
  output logic q15
);

  // Power-up value matters: the one-shot reset generator never asserts reset.
  taps_t     sr_q = INIT;
  taps_t     sr_d;
  tap_addr_t addr;

  always_comb begin
    sr_d = sr_q;
    if (ce) begin
      sr_d = shift_taps(sr_q, d);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sr_q <= INIT;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign addr = {a3, a2, a1, a0};
  assign q    = sr_q[addr];
  assign q15  = sr_q[TAP_COUNT-1];

endmodule

// File: tb/tb_srl16_shift_reg.sv
// Directed checks of srl16_shift_reg across three INIT values.
`timescale 1ns/1ps
module tb_srl16_shift_reg;

  logic clk = 1'b0;
  always #50 clk = ~clk;

  // Instance 0: INIT=FFFF one-shot reset generator; 1: INIT=0 delay line; 2: INIT=1234.
  logic       rst [3];
  logic       ce  [3];
  logic       din [3];
  logic [3:0] adr [3];
  logic       q   [3];
  logic       q15 [3];

  srl16_shift_reg #(.INIT(16'hFFFF)) u_oneshot (
    .clock(clk), .reset(rst[0]), .ce(ce[0]), .d(din[0]),
    .a0(adr[0][0]), .a1(adr[0][1]), .a2(adr[0][2]), .a3(adr[0][3]),
    .q(q[0]), .q15(q15[0])
  );

  srl16_shift_reg #(.INIT(16'h0000)) u_delay (
    .clock(clk), .reset(rst[1]), .ce(ce[1]), .d(din[1]),
    .a0(adr[1][0]), .a1(adr[1][1]), .a2(adr[1][2]), .a3(adr[1][3]),
    .q(q[1]), .q15(q15[1])
  );

  srl16_shift_reg #(.INIT(16'h1234)) u_reload (
    .clock(clk), .reset(rst[2]), .ce(ce[2]), .d(din[2]),
    .a0(adr[2][0]), .a1(adr[2][1]), .a2(adr[2][2]), .a3(adr[2][3]),
    .q(q[2]), .q15(q15[2])
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] pat;
  logic [15:0] init_b;

  initial begin
    rst[0] = 1'b0; ce[0] = 1'b1; din[0] = 1'b0; adr[0] = 4'hF;
    for (int i = 1; i < 3; i++) begin
      rst[i] = 1'b0; ce[i] = 1'b0; din[i] = 1'b0; adr[i] = 4'h0;
    end
    pat    = 16'hA5C3;
    init_b = 16'h1234;
    #1;

    // Power-up contents are INIT without any reset.
    check_bit("oneshot_pwrup_q", q[0], 1'b1);
    check_bit("oneshot_pwrup_q15", q15[0], 1'b1);
    for (int k = 0; k < 16; k++) begin
      adr[2] = 4'(k);
      #1;
      check_bit($sformatf("reload_pwrup_a%0d", k), q[2], init_b[k]);
    end

    // One-shot: q high through edge 15, low from edge 16 on.
    for (int e = 1; e <= 20; e++) begin
      step();
      check_bit($sformatf("oneshot_edge%0d", e), q[0], (e < 16) ? 1'b1 : 1'b0);
    end

    // Single-cycle pulse through the delay line.
    rst[1] = 1'b1; ce[1] = 1'b1; din[1] = 1'b1; adr[1] = 4'h3;
    step();
    check_bit("delay_rst_q", q[1], 1'b0);
    check_bit("delay_rst_q15", q15[1], 1'b0);
    rst[1] = 1'b0;
    step();
    din[1] = 1'b0;
    check_bit("delay_edge0_q", q[1], 1'b0);
    for (int k = 1; k <= 18; k++) begin
      step();
      check_bit($sformatf("delay_a3_k%0d", k), q[1], (k == 3) ? 1'b1 : 1'b0);
      check_bit($sformatf("delay_q15_k%0d", k), q15[1], (k == 15) ? 1'b1 : 1'b0);
    end

    // Reset mid-shift discards shifted data.
    din[1] = 1'b1;
    for (int k = 0; k < 5; k++) step();
    adr[1] = 4'h4;
    #1;
    check_bit("midshift_pre_a4", q[1], 1'b1);
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0; ce[1] = 1'b0;
    check_bit("midshift_q15", q15[1], 1'b0);
    for (int k = 0; k < 5; k++) begin
      adr[1] = 4'(k);
      #1;
      check_bit($sformatf("midshift_a%0d", k), q[1], 1'b0);
    end

    // Load A5C3 MSB first, then hold with ce low while d toggles.
    ce[2] = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      din[2] = pat[i];
      step();
    end
    ce[2] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      din[2] = i[0];
      step();
    end
    check_bit("hold_q15", q15[2], 1'b1);
    // Address sweep between clock edges: read path needs no edge.
    for (int k = 0; k < 16; k++) begin
      adr[2] = 4'(k);
      #2;
      check_bit($sformatf("hold_a%0d", k), q[2], pat[k]);
    end

    // Reset wins over ce=1, d=1.
    rst[2] = 1'b1; ce[2] = 1'b1; din[2] = 1'b1; adr[2] = 4'h2;
    step();
    rst[2] = 1'b0; ce[2] = 1'b0;
    check_bit("rstprio_a2", q[2], 1'b1);
    check_bit("rstprio_q15", q15[2], 1'b0);
    for (int k = 0; k < 16; k++) begin
      adr[2] = 4'(k);
      #2;
      check_bit($sformatf("rstprio_a%0d", k), q[2], init_b[k]);
    end

    // One-shot output stays low long after the drop.
    check_bit("oneshot_late", q[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/srl16_shift_reg.md
Name: srl16_shift_reg

Overview:
- 16-bit, 1-bit-wide serial shift register with an addressable tap output. Behaviour matches the vendor SRL16E/SRLC16E primitive, plus a synchronous reload to INIT.
- Used as a power-up one-time reset generator in the audio subsystem. The configuration there is INIT=16'hFFFF, d=0, address=15; q stays high for 16 clocks after start, then drops low.
- Also serves as a general variable-length delay line of 1 to 16 cycles.

Parameters:
- INIT, 16'h0000: initial register contents, bit i = tap i. Loaded at power-up (register initial value) and on every reset.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; reloads contents with INIT
- ce  input  1  shift enable
- d  input  1  serial data in, enters at tap 0
- a0  input  1  tap address bit 0 (LSB)
- a1  input  1  tap address bit 1
- a2  input  1  tap address bit 2
- a3  input  1  tap address bit 3 (MSB)
- q  output  1  selected tap, sr[{a3,a2,a1,a0}]
- q15  output  1  last tap sr[15], for cascading

Behaviour:
- State: one 16-bit register sr. Power-up value of sr is INIT (register initial value, no reset needed), so the one-time-reset use works without reset ever being asserted.
- On each rising edge of clock:
  - reset=1: sr <= INIT. This takes priority over ce and d.
  - else ce=1: sr <= {sr[14:0], d}. The old sr[15] is discarded.
  - else: sr holds.
- Read path is asynchronous and combinational:
  - q = sr[A], where A = {a3,a2,a1,a0}.
  - q15 = sr[15].
  - Changing address changes q in the same cycle; no clock is required.
- Latency: a bit presented on d with ce=1 at edge n appears on q at address A after edge n+A. So A=0 gives a 1-cycle delay and A=15 gives a 16-cycle delay.
- Reset values: q = INIT[A], q15 = INIT[15].
- Reset mid-operation: all shifted data is lost and contents equal INIT on the next cycle.
- ce and reset both low: q follows address only.
- Address bits and d must be free of X for a defined q. No X-propagation handling is required beyond normal simulation semantics.
- No wrap-around: data shifted past tap 15 is discarded, and only reaches another register if q15 is cascaded externally.

Decomposition:
- Self-contained leaf module; no sub-modules.
- No shared package needed. The tap count (16) and address width (4) may be placed as localparams in the team's common primitives package if one exists.
- Optional thin wrapper srl16_delay, with a 4-bit address bus instead of a0..a3, for general use.

Test Plan:
- One-time reset: INIT=16'hFFFF, ce=1, d=0, a=4'hF, no reset -> q=1 for edges 1..15; q=0 from edge 16 onward and stays 0.
- Delay taps: INIT=0, reset pulse, ce=1, drive d=1 for exactly one cycle -> q15 goes 1 exactly 16 edges later, for one cycle. For a=4'h3, q goes 1 exactly 4 edges after the d=1 edge.
- Clock enable: shift in 16'hA5C3 (MSB first), then ce=0 for 10 cycles with d toggling -> sweeping a=0..15 reads 3,C,5,A nibble bits unchanged (sr == 16'hA5C3).
- Reset priority: contents 16'hA5C3, INIT=16'h1234; assert reset with ce=1, d=1 for one edge -> sr == 16'h1234 and q at a=2 equals 1.
- Combinational read: hold clock, step a from 0 to 15 -> q matches sr[a] in the same delta, with no edge required.
- Reset mid-shift: after 5 shifts of d=1 from INIT=0, reset -> q15=0 and q at a=0..4 are all 0 on the next cycle.
